rv_mem_arb: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data/instruction memory of the multicycle RISC-V core. It shares the memory between the core control path (fetch, load, store) and a debug/loader port. Ownership alternates round-robin under contention. Each access is sequenced through a fixed-latency memory timing with a registered read-data return. It sits between the core's memory interface and the memory macro.

---
 rtl/rv_mem_arb.sv | 149 ++++++++++++++
 tb/tb_rv_mem_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Round-robin arbiter and fixed-latency access sequencer sharing one memory port
// between the core control path and the debug/loader port.
module rv_mem_arb #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_owner;     // 0 = core, 1 = debug
    logic          r_last_gnt;  // 0 = core, 1 = debug
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_d_rdata;

    logic [1:0]    w_state_d;
    logic [CW-1:0] w_cnt_d;
    logic          w_idle;
    logic          w_gnt_c;
    logic          w_gnt_d;
    logic          w_capture;

    // Grant is a Mealy decode of the idle state; gated by rst so outputs read 0 during reset.
    assign w_idle    = (r_state == StIdle) && !rst;
    assign w_gnt_c   = w_idle && c_req && (!d_req || r_last_gnt);
    assign w_gnt_d   = w_idle && d_req && (!c_req || !r_last_gnt);
    assign w_capture = (r_state == StWait) && (r_cnt == '0) && !r_we;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_gnt_c || w_gnt_d) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_state_d = StWait;
                w_cnt_d   = CNT_LOAD;
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt - CW'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_gnt_c) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b0;
            r_we       <= c_we;
            r_addr     <= c_addr;
            r_wdata    <= c_wdata;
        end else if (w_gnt_d) begin
            r_owner    <= 1'b1;
            r_last_gnt <= 1'b1;
            r_we       <= d_we;
            r_addr     <= d_addr;
            r_wdata    <= d_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_capture) begin
            if (r_owner) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_c_rdata <= mem_rdata;
            end
        end
    end

    assign c_gnt     = w_gnt_c;
    assign d_gnt     = w_gnt_d;
    assign c_done    = (r_state == StDone) && !r_owner;
    assign d_done    = (r_state == StDone) && r_owner;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = (r_state == StIssue);
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = mem_en ? r_addr : '0;
    assign mem_wdata = mem_en ? r_wdata : '0;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench for rv_mem_arb: a MEM_LAT=1 instance for the main scenarios and
// a MEM_LAT=3 instance for the long-latency debug read.
module tb_rv_mem_arb;

    typedef struct {
        int port;
        int cyc;
    } gnt_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] c_rd;
        logic [31:0] d_rd;
    } done_t;

    typedef struct {
        int          cyc;
        logic        gnt;
        logic        en;
        logic        busy;
        logic        done;
        logic [31:0] rd;
    } l3_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_chk;
    int          n_fail;

    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_done, d_gnt, d_done;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        c3_req, c3_we, d3_req, d3_we;
    logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
    logic        c3_gnt, c3_done, d3_gnt, d3_done;
    logic [31:0] c3_rdata, d3_rdata;
    logic        mem3_en, mem3_we, busy3;
    logic [31:0] mem3_addr, mem3_wdata, mem3_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] p1, p2, p3;

    gnt_t  q_gnt[$];
    mem_t  q_mem[$];
    done_t q_done[$];
    l3_t   q3[$];
    logic [31:0] m_c, m_d;

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .c_req(c3_req), .c_we(c3_we), .c_addr(c3_addr), .c_wdata(c3_wdata),
        .c_gnt(c3_gnt), .c_done(c3_done), .c_rdata(c3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_done(d3_done), .d_rdata(d3_rdata),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: one-cycle registered read, and a three-stage read pipeline.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
        p1 <= (mem3_en && !mem3_we) ? mem[mem3_addr[7:0]] : 32'h0;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem3_rdata = p3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    gnt_t  eg;
    mem_t  em;
    done_t ed;
    l3_t   e3;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ctrl", {25'b0, c_gnt, c_done, d_gnt, d_done, mem_en, mem_we, busy}, 32'h0);
            check("rst_data", mem_addr | mem_wdata | c_rdata | d_rdata, 32'h0);
        end else begin
            check("single_gnt", {31'b0, c_gnt & d_gnt}, 32'h0);
            if (c_gnt || d_gnt) begin
                if (q_gnt.size() == 0) begin
                    check("unexpected_gnt", {30'b0, c_gnt, d_gnt}, 32'h0);
                end else begin
                    eg = q_gnt.pop_front();
                    check("gnt_port", {30'b0, c_gnt, d_gnt}, (eg.port == 1) ? 32'd1 : 32'd2);
                    check("gnt_cycle", cyc, eg.cyc);
                    check("gnt_busy", {31'b0, busy}, 32'h0);
                end
            end
            if (mem_en) begin
                if (q_mem.size() == 0) begin
                    check("unexpected_mem_en", {31'b0, mem_en}, 32'h0);
                end else begin
                    em = q_mem.pop_front();
                    check("mem_cycle", cyc, em.cyc);
                    check("mem_we", {31'b0, mem_we}, {31'b0, em.we});
                    check("mem_addr", mem_addr, em.addr);
                    check("mem_wdata", mem_wdata, em.wdata);
                end
            end else begin
                check("mem_idle_zero", {31'b0, mem_we} | mem_addr | mem_wdata, 32'h0);
            end
            if (c_done || d_done) begin
                if (q_done.size() == 0) begin
                    check("unexpected_done", {30'b0, c_done, d_done}, 32'h0);
                end else begin
                    ed = q_done.pop_front();
                    check("done_port", {30'b0, c_done, d_done}, (ed.port == 1) ? 32'd1 : 32'd2);
                    check("done_cycle", cyc, ed.cyc);
                    check("done_c_rdata", c_rdata, ed.c_rd);
                    check("done_d_rdata", d_rdata, ed.d_rd);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && q3.size() > 0 && q3[0].cyc == cyc) begin
            e3 = q3.pop_front();
            check("l3_gnt", {31'b0, d3_gnt}, {31'b0, e3.gnt});
            check("l3_mem_en", {31'b0, mem3_en}, {31'b0, e3.en});
            check("l3_busy", {31'b0, busy3}, {31'b0, e3.busy});
            check("l3_done", {31'b0, d3_done}, {31'b0, e3.done});
            check("l3_rdata", d3_rdata, e3.rd);
            check("l3_core_quiet", {30'b0, c3_gnt, c3_done}, 32'h0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port == 0) begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        q_gnt.push_back('{port, cyc});
        q_mem.push_back('{cyc + 1, we, addr, wdata});
    endtask

    task automatic expect_done(input int port, input int dcyc, input logic [31:0] rd);
        if (port == 0) m_c = rd;
        else           m_d = rd;
        q_done.push_back('{port, dcyc, m_c, m_d});
    endtask

    int g;

    initial begin
        n_chk = 0; n_fail = 0;
        m_c = 32'h0; m_d = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h40] = 32'hC0DE0040;
        mem[8'h50] = 32'hD0D00050;
        mem[8'h60] = 32'h600D0060;
        mem[8'h70] = 32'hCAFE0070;
        mem_rdata = 32'h0;
        p1 = 32'h0; p2 = 32'h0; p3 = 32'h0;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
        d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);

        // Core read
        g = cyc;
        start(0, 1'b0, 32'h10, 32'h0);
        expect_done(0, g + 3, 32'hDEADBEEF);
        wait_cycles(4);
        c_req = 1'b0;

        // Core write: c_rdata keeps its previous value
        g = cyc;
        start(0, 1'b1, 32'h20, 32'h12345678);
        expect_done(0, g + 3, m_c);
        wait_cycles(4);
        c_req = 1'b0; c_we = 1'b0; c_wdata = 32'h0;

        // Debug read-back of the written word
        g = cyc;
        start(1, 1'b0, 32'h20, 32'h0);
        expect_done(1, g + 3, 32'h12345678);
        wait_cycles(4);
        d_req = 1'b0;

        // Inputs changed after grant have no effect
        g = cyc;
        start(0, 1'b0, 32'h60, 32'h0);
        expect_done(0, g + 3, 32'h600D0060);
        wait_cycles(1);
        c_req = 1'b0; c_addr = 32'h99; c_we = 1'b1; c_wdata = 32'hFFFFFFFF;
        wait_cycles(3);
        c_we = 1'b0; c_wdata = 32'h0;

        // Reset during WAIT aborts the core read; lone d_req granted right after release
        g = cyc;
        start(0, 1'b0, 32'h40, 32'h0);
        wait_cycles(2);
        rst = 1'b1;
        c_req = 1'b0;
        m_c = 32'h0; m_d = 32'h0;
        wait_cycles(2);
        rst = 1'b0;
        g = cyc;
        start(1, 1'b0, 32'h10, 32'h0);
        expect_done(1, g + 3, 32'hDEADBEEF);
        wait_cycles(4);
        d_req = 1'b0;

        // Contention from reset: C, D, C, D four cycles apart
        rst = 1'b1;
        m_c = 32'h0; m_d = 32'h0;
        wait_cycles(2);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        rst = 1'b0;
        g = cyc;
        q_gnt.push_back('{0, g});
        q_gnt.push_back('{1, g + 4});
        q_gnt.push_back('{0, g + 8});
        q_gnt.push_back('{1, g + 12});
        q_mem.push_back('{g + 1, 1'b0, 32'h40, 32'h0});
        q_mem.push_back('{g + 5, 1'b0, 32'h50, 32'h0});
        q_mem.push_back('{g + 9, 1'b0, 32'h60, 32'h0});
        q_mem.push_back('{g + 13, 1'b0, 32'h10, 32'h0});
        expect_done(0, g + 3, 32'hC0DE0040);
        expect_done(1, g + 7, 32'hD0D00050);
        expect_done(0, g + 11, 32'h600D0060);
        expect_done(1, g + 15, 32'hDEADBEEF);
        wait_cycles(1);
        c_addr = 32'h60;
        wait_cycles(4);
        d_addr = 32'h10;
        wait_cycles(8);
        c_req = 1'b0; d_req = 1'b0;
        wait_cycles(4);

        // MEM_LAT=3 debug read
        g = cyc;
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h70;
        q3.push_back('{g,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        q3.push_back('{g + 1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
        q3.push_back('{g + 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
        q3.push_back('{g + 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
        q3.push_back('{g + 4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
        q3.push_back('{g + 5, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE0070});
        q3.push_back('{g + 6, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE0070});
        wait_cycles(1);
        d3_req = 1'b0;
        wait_cycles(8);

        check("gnt_left", q_gnt.size(), 32'h0);
        check("mem_left", q_mem.size(), 32'h0);
        check("done_left", q_done.size(), 32'h0);
        check("l3_left", q3.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
